// File: rtl/piso_pkg.sv
// piso_pkg: shared sizing helpers and bit-order constants for the PISO serializer.
package piso_pkg;
  localparam bit MSB_FIRST_ORDER = 1'b1;
  localparam bit LSB_FIRST_ORDER = 1'b0;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int beats_of(input int width, input int lanes);
    return (lanes > 0) ? width / lanes : 1;
  endfunction
endpackage

// File: rtl/piso_shift_core.sv
// piso_shift_core: shift register, beat counter and active flag that emit one word lane by lane.
module piso_shift_core
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = MSB_FIRST_ORDER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             consume,
  output logic             active,
  output logic [LANES-1:0] dataout,
  output logic             last
);
  localparam int BEATS = beats_of(WIDTH, LANES);
  localparam int CW = clog2_min1(BEATS);
  localparam logic [CW-1:0] LAST_COUNT = CW'(BEATS - 1);
  localparam bit MSB = (MSB_FIRST != LSB_FIRST_ORDER);
  logic [WIDTH-1:0] shreg, shreg_next, shifted;
  logic [CW-1:0] count, count_next;
  logic active_next;
  assign shifted = MSB ? shreg << LANES : shreg >> LANES;
  assign dataout = MSB ? shreg[WIDTH-1 -: LANES] : shreg[LANES-1:0];
  assign last = active && (count == LAST_COUNT);
  // The final shift zero-fills the register, so an idle core presents dataout=0.
  always_comb begin
    shreg_next  = load ? word : consume ? shifted : shreg;
    count_next  = (load || (consume && last)) ? '0 : consume ? count + 1'b1 : count;
    active_next = load ? 1'b1 : (consume && last) ? 1'b0 : active;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      count  <= '0;
      active <= 1'b0;
    end else begin
      shreg  <= shreg_next;
      count  <= count_next;
      active <= active_next;
    end
  end
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready PISO serializer with a one-word pending buffer for gapless streaming.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = MSB_FIRST_ORDER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] datain,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic [LANES-1:0] dataout,
  output logic             last,
  output logic             busy
);
  if (LANES < 1 || LANES > WIDTH || (WIDTH % LANES) != 0) begin : g_bad_cfg
    $error("piso_serializer: WIDTH must be a positive multiple of LANES");
  end
  logic [WIDTH-1:0] pend, core_word;
  logic pend_full, active, consume, last_done, accept, direct, core_load;
  assign load_ready = !pend_full;
  assign sout_valid = active;
  assign busy = active || pend_full;
  assign consume = active && sout_ready;
  assign last_done = consume && last;
  assign accept = load_valid && load_ready;
  assign direct = accept && (!active || last_done);
  // Loads are refused while pend is full, so a pend drain never collides with datain.
  assign core_load = direct || (last_done && pend_full);
  assign core_word = pend_full ? pend : datain;
  piso_shift_core #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk(clk),
    .reset(reset),
    .load(core_load),
    .word(core_word),
    .consume(consume),
    .active(active),
    .dataout(dataout),
    .last(last)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend      <= '0;
      pend_full <= 1'b0;
    end else if (accept && !direct) begin
      pend      <= datain;
      pend_full <= 1'b1;
    end else if (last_done && pend_full) begin
      pend      <= '0;
      pend_full <= 1'b0;
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: three configurations (LANES=1 MSB, LANES=1 LSB, LANES=2 MSB) checked by a word-level scoreboard.
module tb_piso_serializer;
  logic clk;
  int total = 0;
  int bad = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input int cfg, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL cfg%0d %s got=%0h expected=%0h at %0t", cfg, name, act, exp, $time);
    end
  endtask
  for (genvar c = 0; c < 3; c++) begin : g
    localparam int L = (c == 2) ? 2 : 1;
    localparam bit M = (c != 1);
    localparam int B = 8 / L;
    logic reset, load_valid, load_ready, sout_valid, sout_ready, last, busy;
    logic [7:0] datain;
    logic [L-1:0] dataout;
    bit done = 1'b0;
    int q[$];
    int nw = 0;
    piso_serializer #(.WIDTH(8), .LANES(L), .MSB_FIRST(M)) dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
      .datain(datain), .sout_valid(sout_valid), .sout_ready(sout_ready),
      .dataout(dataout), .last(last), .busy(busy)
    );
    function automatic int beat_of(input logic [7:0] w, input int i);
      int sh;
      sh = M ? 8 - L * (i + 1) : L * i;
      return (int'(w) >> sh) & ((1 << L) - 1);
    endfunction
    always @(negedge clk) begin
      bit acc;
      if (reset) begin
        q.delete();
        nw = 0;
      end else begin
        acc = load_valid && (nw < 2);
        chk(c, "sout_valid", sout_valid, q.size() > 0);
        chk(c, "load_ready", load_ready, nw < 2);
        chk(c, "busy", busy, nw > 0);
        if (sout_valid && q.size() > 0) begin
          chk(c, "dataout", dataout, q[0] >> 1);
          chk(c, "last", last, q[0] & 1);
        end
        if (sout_valid && sout_ready && q.size() > 0) begin
          if (q[0] & 1) nw--;
          void'(q.pop_front());
        end
        if (acc) begin
          for (int i = 0; i < B; i++) q.push_back(beat_of(datain, i) * 2 + ((i == B - 1) ? 1 : 0));
          nw++;
        end
      end
    end
    task automatic send(input logic [7:0] w);
      int n;
      load_valid = 1'b1;
      datain = w;
      n = 0;
      @(negedge clk);
      while (!load_ready && n < 50) begin
        n++;
        @(negedge clk);
      end
      if (n >= 50) chk(c, "send_timeout", 1, 0);
      @(posedge clk);
      #1 load_valid = 1'b0;
    endtask
    task automatic wait_idle();
      for (int n = 0; n < 200 && busy; n++) begin
        @(posedge clk);
        #1;
      end
      chk(c, "idle_busy", busy, 0);
      chk(c, "idle_valid", sout_valid, 0);
    endtask
    task automatic chk_reset_outputs();
      chk(c, "rst_valid", sout_valid, 0);
      chk(c, "rst_ready", load_ready, 1);
      chk(c, "rst_busy", busy, 0);
      chk(c, "rst_dataout", dataout, 0);
      chk(c, "rst_last", last, 0);
    endtask
    initial begin
      reset = 1'b1;
      load_valid = 1'b0;
      datain = '0;
      sout_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk_reset_outputs();
      @(posedge clk);
      #2 reset = 1'b0;
      sout_ready = 1'b1;
      send(8'b11011101);
      wait_idle();
      send(8'hA5);
      send(8'h3C);
      wait_idle();
      send(8'b11011101);
      repeat (3) @(posedge clk);
      #1 sout_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 sout_ready = 1'b1;
      wait_idle();
      send(8'b11011101);
      send(8'h3C);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 chk_reset_outputs();
      @(posedge clk);
      #2 reset = 1'b0;
      repeat (5) @(posedge clk);
      #1 chk(c, "post_reset_quiet", sout_valid, 0);
      for (int k = 0; k < 400; k++) begin
        @(posedge clk);
        #1;
        load_valid = 1'($urandom_range(0, 1));
        datain = 8'($urandom);
        sout_ready = ($urandom_range(0, 3) != 0);
      end
      load_valid = 1'b0;
      sout_ready = 1'b1;
      wait_idle();
      done = 1'b1;
    end
  end
  initial begin
    for (int n = 0; n < 20000 && !(g[0].done && g[1].done && g[2].done); n++) @(posedge clk);
    if (!(g[0].done && g[1].done && g[2].done)) begin
      total++;
      bad++;
      $display("FAIL timeout: stimulus did not complete");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out serializer. Successor to the basic fixed-size PISO shift register.
- Adds a configurable word width, lanes per beat (1..N output bits per cycle) and bit order.
- Input and output are valid/ready handshakes, with a one-word pending buffer so consecutive words serialize with no gap beats.
- Sits between parallel datapath producers and narrow serial links or test outputs.

Parameters:
- WIDTH, 8: parallel word width in bits; must be a multiple of LANES.
- LANES, 1: output bits per beat; BEATS = WIDTH/LANES.
- MSB_FIRST, 1: 1 = most significant lane emitted first; 0 = least significant lane emitted first.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- load_valid  in  1  datain holds a word to load.
- load_ready  out  1  block can accept a word this cycle.
- datain  in  WIDTH  parallel input word.
- sout_valid  out  1  dataout holds a valid beat.
- sout_ready  in  1  consumer accepts the beat this cycle.
- dataout  out  LANES  current serial beat.
- last  out  1  current beat is the final beat of its word.
- busy  out  1  shift register or pending buffer occupied.

Behaviour:
- Reset (asynchronous, active-high):
  - sout_valid=0, dataout=0, last=0, busy=0, load_ready=1.
  - Beat counter = 0; shift register and pending buffer cleared and marked empty.
  - Reset mid-word discards the partial word and any pending word; no beat is emitted afterward until a new load.
- Internal state:
  - shreg[WIDTH], active flag, beat count [clog2(BEATS)].
  - pend[WIDTH], pend_full flag.
- Input handshake:
  - load_ready = !pend_full. It is purely a function of registered state, with no combinational path from sout_ready.
  - Load accepted when load_valid && load_ready.
- Load routing on an accepted load:
  - If !active, or the last beat is consumed this cycle: the word goes directly into shreg; active=1; count=0.
  - Otherwise: the word goes into pend; pend_full=1.
- Output:
  - sout_valid = active.
  - dataout = shreg[WIDTH-1 -: LANES] if MSB_FIRST, else shreg[LANES-1:0].
  - last = active && (count == BEATS-1).
- Beat consumption (sout_valid && sout_ready):
  - Not last beat: shreg shifts by LANES (left if MSB_FIRST, right otherwise, zero-fill); count+1.
  - Last beat with pend_full: shreg<=pend, pend_full=0, count=0, active stays 1. The next word's first beat follows in the next cycle with no bubble.
  - Last beat with !pend_full and a load accepted in the same cycle: the load goes directly to shreg (gapless).
  - Last beat with neither: active=0.
- Stall: while sout_valid && !sout_ready, shreg, count, dataout and last hold stable.
- Latency: a word accepted at edge N has its first beat valid after edge N (when !active). One word streams in BEATS cycles when sout_ready is held high.
- Full boundary: with active && pend_full, load_ready=0 and load_valid is ignored, even in the cycle where the last beat is consumed. load_ready rises in the following cycle.
- busy = active || pend_full.
- Elaboration check: WIDTH % LANES != 0 or LANES > WIDTH is an elaboration error.

Decomposition:
- Shared package piso_pkg:
  - Function clog2_min1 for the counter width.
  - Localparam helper for BEATS.
  - Constants for MSB_FIRST/LSB_FIRST.
- Sub-module piso_shift_core holds shreg, count, active and the shift/emit logic.
- Top level piso_serializer adds the pending buffer and load handshake routing.

Test Plan:
- WIDTH=8, LANES=1, MSB_FIRST=1; load 8'b11011101 with sout_ready=1 -> dataout 1,1,0,1,1,1,0,1 on 8 consecutive cycles; last high only on the 8th beat; then sout_valid=0.
- Same word with MSB_FIRST=0 -> dataout 1,0,1,1,1,0,1,1; last on the 8th beat.
- LANES=2, MSB_FIRST=1, word 8'b11011101 -> dataout 2'b11, 2'b01, 2'b11, 2'b01; last on the 4th beat.
- Back-to-back: load 8'hA5 then 8'h3C while the first is shifting -> 16 contiguous valid beats (10100101 then 00111100); load_ready=0 while pend is full; no idle beat between words.
- Backpressure: sout_ready low for 3 cycles at beat 4 of 8'b11011101 -> dataout holds 1 and count holds; resume completes the word correctly.
- Reset asserted mid-word at beat 3, with a pending word present -> outputs 0 and load_ready=1 immediately (asynchronously); after release no beats until a new load.
